heichips25_nibble_rx: RTL and testbench

HEICHIPS25_NIBBLE_RX -- requirements
Module: heichips25_nibble_rx

---
 rtl/heichips25_nibble_rx.sv | 145 ++++++++++++++
 tb/tb_heichips25_nibble_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/heichips25_nibble_rx.sv
// ============================================================================
// Module  : heichips25_nibble_rx
// Brief   : Reassembles bytes from nibble strobes on one half of a shared bus
//           and queues them in a first-word-fall-through byte FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module heichips25_nibble_rx #(
  parameter int LANE       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_in,
  input  logic       strobe_in,
  input  logic       first_in,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       ovf,
  input  logic       clr_ovf,
  output logic [7:0] err_cnt,
  output logic [4:0] fill
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    HAVE_LOW = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  low_q, low_d;
  logic        push_w;
  logic        err_w;
  logic [7:0]  push_byte_w;
  logic [3:0]  nibble_w;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    count_q, count_d;
  logic [7:0]    err_q;
  logic          ovf_q;
  logic          pop_w, full_w, accept_w, drop_w;

  generate
    if (LANE == 0) begin : g_lane_hi
      assign nibble_w = bus_in[7:4];
    end else begin : g_lane_lo
      assign nibble_w = bus_in[3:0];
    end
  endgenerate

  // Receive FSM: next state, held low nibble and push/error strobes.
  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    push_w      = 1'b0;
    err_w       = 1'b0;
    push_byte_w = {nibble_w, low_q};
    if (strobe_in) begin
      case (state_q)
        IDLE: begin
          if (first_in) begin
            low_d   = nibble_w;
            state_d = HAVE_LOW;
          end else begin
            err_w = 1'b1;
          end
        end
        HAVE_LOW: begin
          if (first_in) begin
            err_w = 1'b1;
            low_d = nibble_w;
          end else begin
            push_w  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      low_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      low_q   <= low_d;
    end
  end

  assign pop_w    = (count_q != 5'd0) && m_ready;
  assign full_w   = (count_q == DEPTH_C);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign accept_w = push_w && (!full_w || pop_w);
  assign drop_w   = push_w && full_w && !pop_w;

  always_comb begin
    count_d = count_q;
    if (accept_w && !pop_w)      count_d = count_q + 5'd1;
    else if (!accept_w && pop_w) count_d = count_q - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
    end else begin
      if (accept_w) begin
        mem_q[wr_ptr_q] <= push_byte_w;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= 8'h00;
    end else begin
      if (drop_w)       ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
      if (err_w && (err_q != 8'hFF)) err_q <= err_q + 8'h01;
    end
  end

  assign m_data  = mem_q[rd_ptr_q];
  assign m_valid = (count_q != 5'd0);
  assign ovf     = ovf_q;
  assign err_cnt = err_q;
  assign fill    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_heichips25_nibble_rx.sv
// ============================================================================
// Module  : tb_heichips25_nibble_rx
// Brief   : Directed vector bench for heichips25_nibble_rx (both lanes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_heichips25_nibble_rx;

  logic       clk;
  logic       rst;
  logic [7:0] bus_in;
  logic       strobe_in, first_in, m_ready, clr_ovf;
  logic [7:0] m_data;
  logic       m_valid, ovf;
  logic [7:0] err_cnt;
  logic [4:0] fill;

  logic [7:0] l_bus;
  logic       l_strobe, l_first, l_ready, l_clr;
  logic [7:0] l_data;
  logic       l_valid, l_ovf;
  logic [7:0] l_err;
  logic [4:0] l_fill;

  int checks = 0;
  int errors = 0;

  heichips25_nibble_rx #(.LANE(0), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .strobe_in(strobe_in),
    .first_in(first_in), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .ovf(ovf), .clr_ovf(clr_ovf), .err_cnt(err_cnt),
    .fill(fill)
  );

  heichips25_nibble_rx #(.LANE(1), .FIFO_DEPTH(4)) u_lane (
    .clk(clk), .rst(rst), .bus_in(l_bus), .strobe_in(l_strobe),
    .first_in(l_first), .m_data(l_data), .m_valid(l_valid),
    .m_ready(l_ready), .ovf(l_ovf), .clr_ovf(l_clr), .err_cnt(l_err),
    .fill(l_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       strobe;
    logic       first;
    logic [7:0] bus;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ef;
    logic       eo;
    logic [7:0] ee;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic f, input logic [7:0] b, input logic r,
                     input logic c, input logic ev, input logic [7:0] ed,
                     input logic [4:0] ef, input logic eo, input logic [7:0] ee);
    vecs[nv] = '{s, f, b, r, c, ev, ed, ef, eo, ee};
    nv++;
  endtask

  task automatic drive(input logic s, input logic f, input logic [7:0] b,
                       input logic r, input logic c);
    strobe_in = s; first_in = f; bus_in = b; m_ready = r; clr_ovf = c;
    @(posedge clk);
    #1;
    strobe_in = 1'b0; first_in = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_in = 8'h00; strobe_in = 1'b0; first_in = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    l_bus = 8'h00; l_strobe = 1'b0; l_first = 1'b0; l_ready = 1'b0; l_clr = 1'b0;

    // basic byte, pop, ready on empty
    add(1, 1, 8'h5F, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'hA3, 0, 0, 1, 8'hA5, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    // framing errors
    add(1, 0, 8'h90, 0, 0, 0, 8'h00, 0, 0, 1);
    add(1, 1, 8'h10, 0, 0, 0, 8'h00, 0, 0, 1);
    add(1, 1, 8'h20, 0, 0, 0, 8'h00, 0, 0, 2);
    add(0, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 0, 2);
    add(1, 0, 8'h70, 0, 0, 1, 8'h72, 1, 0, 2);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2);
    // overflow: five bytes 11..55 into a depth-4 FIFO
    for (int k = 1; k <= 5; k++) begin
      add(1, 1, {4'(k), 4'hE}, 0, 0, (k > 1), 8'h11, 5'((k - 1 > 4) ? 4 : k - 1), 0, 2);
      add(1, 0, {4'(k), 4'h1}, 0, 0, 1, 8'h11, 5'((k > 4) ? 4 : k), (k == 5), 2);
    end
    for (int i = 1; i <= 4; i++)
      add(0, 0, 8'h00, 1, 0, (i < 4), {4'(i + 1), 4'(i + 1)}, 5'(4 - i), 1, 2);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 2);
    // refill with 66..99
    for (int k = 6; k <= 9; k++) begin
      add(1, 1, {4'(k), 4'h0}, 0, 0, (k > 6), 8'h66, 5'(k - 6), 0, 2);
      add(1, 0, {4'(k), 4'h0}, 0, 0, 1, 8'h66, 5'(k - 5), 0, 2);
    end
    // full with simultaneous pop, then overflow with clear (set wins)
    add(1, 1, 8'hA0, 0, 0, 1, 8'h66, 4, 0, 2);
    add(1, 0, 8'hA0, 1, 0, 1, 8'h77, 4, 0, 2);
    add(1, 1, 8'hB0, 0, 0, 1, 8'h77, 4, 0, 2);
    add(1, 0, 8'hB0, 0, 1, 1, 8'h77, 4, 1, 2);
    add(0, 0, 8'h00, 0, 1, 1, 8'h77, 4, 0, 2);
    add(0, 0, 8'h00, 1, 0, 1, 8'h88, 3, 0, 2);
    add(0, 0, 8'h00, 1, 0, 1, 8'h99, 2, 0, 2);
    add(0, 0, 8'h00, 1, 0, 1, 8'hAA, 1, 0, 2);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err_cnt, 0);

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].strobe, vecs[i].first, vecs[i].bus, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("v%0d_valid", i), m_valid, vecs[i].ev);
      chk($sformatf("v%0d_fill", i), fill, vecs[i].ef);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].eo);
      chk($sformatf("v%0d_err", i), err_cnt, vecs[i].ee);
      if (vecs[i].ev) chk($sformatf("v%0d_data", i), m_data, vecs[i].ed);
    end

    // reset while holding a low nibble with two bytes queued
    drive(1, 1, 8'h10, 0, 0);
    drive(1, 0, 8'h20, 0, 0);
    drive(1, 1, 8'h30, 0, 0);
    drive(1, 0, 8'h40, 0, 0);
    drive(1, 1, 8'h50, 0, 0);
    chk("pre_rst_fill", fill, 2);
    chk("pre_rst_data", m_data, 8'h21);
    rst = 1'b1;
    drive(1, 0, 8'h60, 0, 0);
    rst = 1'b0;
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_fill", fill, 0);
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_data", m_data, 8'h00);
    drive(1, 0, 8'h70, 0, 0);
    chk("post_rst_orphan_err", err_cnt, 1);
    chk("post_rst_orphan_valid", m_valid, 0);

    // error counter saturation
    for (int i = 0; i < 254; i++) drive(1, 0, 8'h00, 0, 0);
    chk("err_255", err_cnt, 8'hFF);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h00, 0, 0);
    chk("err_sat", err_cnt, 8'hFF);

    // lane 1: nibbles come from bus_in[3:0], upper bits are noise
    begin
      logic [3:0] r;
      chk("lane_rst_valid", l_valid, 0);
      r = 4'($urandom());
      l_bus = {r, 4'h3}; l_strobe = 1'b1; l_first = 1'b1;
      @(posedge clk); #1;
      r = 4'($urandom());
      l_bus = {r, 4'hC}; l_first = 1'b0;
      @(posedge clk); #1;
      l_strobe = 1'b0;
      chk("lane_valid", l_valid, 1);
      chk("lane_data", l_data, 8'hC3);
      chk("lane_err", l_err, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
